// File: rtl/gps_pkg.sv
// gps_pkg: shared GPS C/A timing constants and navigation preset words
package gps_pkg;

    localparam int CA_CODE_LEN    = 1023;
    localparam int EPOCHS_PER_BIT = 20;
    localparam int WORD_BITS      = 30;

    typedef logic [29:0] nav_word_t;

    typedef enum logic [1:0] {
        PSEL_TLM   = 2'd0,
        PSEL_ONES  = 2'd1,
        PSEL_ZEROS = 2'd2,
        PSEL_ALT   = 2'd3
    } preset_sel_e;

    // TLM preamble 10001011 followed by zeros
    localparam nav_word_t PRESET0 = 30'h22C00000;
    localparam nav_word_t PRESET1 = 30'h3FFFFFFF;
    localparam nav_word_t PRESET2 = 30'h00000000;
    localparam nav_word_t PRESET3 = 30'h15555555;

    function automatic nav_word_t preset_word(input preset_sel_e sel);
        return sel == PSEL_TLM  ? PRESET0 :
               sel == PSEL_ONES ? PRESET1 :
               sel == PSEL_ZEROS ? PRESET2 : PRESET3;
    endfunction

endpackage

// File: rtl/nav_timing_cntr.sv
// nav_timing_cntr: chip/epoch/bit counters and registered boundary pulses
module nav_timing_cntr #(
    parameter int CA_CODE_LEN    = gps_pkg::CA_CODE_LEN,
    parameter int EPOCHS_PER_BIT = gps_pkg::EPOCHS_PER_BIT,
    parameter int WORD_BITS      = gps_pkg::WORD_BITS,
    localparam int BW            = $clog2(WORD_BITS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          sync_i,
    output logic [BW-1:0] bit_idx_o,
    output logic          word_bnd_o,
    output logic          epoch_o,
    output logic          bit_start_o,
    output logic          word_start_o
);
    import gps_pkg::*;

    localparam int CW = $clog2(CA_CODE_LEN);
    localparam int EW = $clog2(EPOCHS_PER_BIT);

    logic [CW-1:0] chip_q, chip_d;
    logic [EW-1:0] epoch_cnt_q, epoch_cnt_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic          epoch_q, epoch_d;
    logic          bit_start_q, bit_start_d;
    logic          word_start_q, word_start_d;
    logic          chip_wrap, epoch_wrap, bit_wrap;
    logic          step_epoch, step_bit, step_word;

    // Cascaded counters; sync restarts the whole hierarchy and forces bit/word pulses but not an epoch pulse
    always_comb begin
        chip_wrap    = chip_q == CW'(CA_CODE_LEN - 1);
        epoch_wrap   = epoch_cnt_q == EW'(EPOCHS_PER_BIT - 1);
        bit_wrap     = bit_idx_q == BW'(WORD_BITS - 1);
        step_epoch   = ena_i & chip_wrap;
        step_bit     = step_epoch & epoch_wrap;
        step_word    = step_bit & bit_wrap;
        chip_d       = sync_i ? '0 : ena_i ? (chip_wrap ? '0 : chip_q + 1'b1) : chip_q;
        epoch_cnt_d  = sync_i ? '0 : step_epoch ? (epoch_wrap ? '0 : epoch_cnt_q + 1'b1) : epoch_cnt_q;
        bit_idx_d    = sync_i ? '0 : step_bit ? (bit_wrap ? '0 : bit_idx_q + 1'b1) : bit_idx_q;
        epoch_d      = step_epoch & ~sync_i;
        bit_start_d  = sync_i | step_bit;
        word_start_d = sync_i | step_word;
    end

    // Counter and pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chip_q       <= '0;
            epoch_cnt_q  <= '0;
            bit_idx_q    <= '0;
            epoch_q      <= 1'b0;
            bit_start_q  <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            chip_q       <= chip_d;
            epoch_cnt_q  <= epoch_cnt_d;
            bit_idx_q    <= bit_idx_d;
            epoch_q      <= epoch_d;
            bit_start_q  <= bit_start_d;
            word_start_q <= word_start_d;
        end
    end

    assign bit_idx_o    = bit_idx_q;
    assign word_bnd_o   = word_start_d;
    assign epoch_o      = epoch_q;
    assign bit_start_o  = bit_start_q;
    assign word_start_o = word_start_q;

endmodule

// File: rtl/nav_msg_gen.sv
// nav_msg_gen: navigation data bit generator with preset and serially loaded words
module nav_msg_gen #(
    parameter int CA_CODE_LEN    = gps_pkg::CA_CODE_LEN,
    parameter int EPOCHS_PER_BIT = gps_pkg::EPOCHS_PER_BIT,
    parameter int WORD_BITS      = gps_pkg::WORD_BITS
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ena_in,
    input  logic       sync_in,
    input  logic       use_msg_preset_in,
    input  logic [1:0] preset_sel_in,
    input  logic       load_valid_in,
    input  logic       load_bit_in,
    output logic       msg_out,
    output logic       epoch_out,
    output logic       bit_start_out,
    output logic       word_start_out,
    output logic       load_full_out
);
    import gps_pkg::*;

    localparam int BW = $clog2(WORD_BITS);

    logic [WORD_BITS-1:0] active_word_q, active_word_d;
    logic [WORD_BITS-1:0] staging_q, staging_d;
    logic [BW-1:0]        load_cnt_q, load_cnt_d;
    logic                 full_q, full_d;
    logic [BW-1:0]        bit_idx;
    logic                 word_bnd;
    logic                 load_take, load_last, transfer;

    nav_timing_cntr #(
        .CA_CODE_LEN   (CA_CODE_LEN),
        .EPOCHS_PER_BIT(EPOCHS_PER_BIT),
        .WORD_BITS     (WORD_BITS)
    ) u_timing (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .ena_i       (ena_in),
        .sync_i      (sync_in),
        .bit_idx_o   (bit_idx),
        .word_bnd_o  (word_bnd),
        .epoch_o     (epoch_out),
        .bit_start_o (bit_start_out),
        .word_start_o(word_start_out)
    );

    // Staging shifts until full; transfer uses the pre-edge full flag so a word completing on a boundary waits one word
    always_comb begin
        load_take     = load_valid_in & ~full_q;
        load_last     = load_cnt_q == BW'(WORD_BITS - 1);
        transfer      = word_bnd & ~use_msg_preset_in & full_q;
        staging_d     = load_take ? {staging_q[WORD_BITS-2:0], load_bit_in} : staging_q;
        load_cnt_d    = load_take ? (load_last ? '0 : load_cnt_q + 1'b1) : load_cnt_q;
        full_d        = (load_take & load_last) | (full_q & ~transfer);
        active_word_d = !word_bnd ? active_word_q :
                        use_msg_preset_in ? WORD_BITS'(preset_word(preset_sel_e'(preset_sel_in))) :
                        full_q ? staging_q : active_word_q;
    end

    // Word, staging and load-count registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_word_q <= WORD_BITS'(PRESET0);
            staging_q     <= '0;
            load_cnt_q    <= '0;
            full_q        <= 1'b0;
        end else begin
            active_word_q <= active_word_d;
            staging_q     <= staging_d;
            load_cnt_q    <= load_cnt_d;
            full_q        <= full_d;
        end
    end

    assign msg_out       = active_word_q[BW'(WORD_BITS - 1) - bit_idx];
    assign load_full_out = full_q;

endmodule

// File: tb/tb_nav_msg_gen.sv
// tb_nav_msg_gen: directed checks of nav_msg_gen with shortened code/epoch lengths
module tb_nav_msg_gen;

    localparam int CHIPS = 7;
    localparam int EPB   = 3;
    localparam int WB    = 30;
    localparam int BITP  = CHIPS * EPB;
    localparam int WORDP = BITP * WB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       sync = 1'b0;
    logic       use_preset = 1'b1;
    logic [1:0] sel = 2'd0;
    logic       lv = 1'b0;
    logic       lb = 1'b0;
    logic       msg, epoch, bit_start, word_start, full;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [29:0] p0 = 30'h22C00000;
    logic [29:0] p3 = 30'h15555555;
    logic [29:0] wa = 30'h2AAAAAAA;

    always #5 clk = ~clk;

    nav_msg_gen #(
        .CA_CODE_LEN   (CHIPS),
        .EPOCHS_PER_BIT(EPB),
        .WORD_BITS     (WB)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .ena_in           (ena),
        .sync_in          (sync),
        .use_msg_preset_in(use_preset),
        .preset_sel_in    (sel),
        .load_valid_in    (lv),
        .load_bit_in      (lb),
        .msg_out          (msg),
        .epoch_out        (epoch),
        .bit_start_out    (bit_start),
        .word_start_out   (word_start),
        .load_full_out    (full)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lv = 1'b0;
        sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        ena = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL reset_msg got=%b exp=1", msg); end
        checks++; if (epoch !== 1'b0) begin failures++; $display("FAIL reset_epoch got=%b exp=0", epoch); end
        checks++; if (bit_start !== 1'b0) begin failures++; $display("FAIL reset_bit_start got=%b exp=0", bit_start); end
        checks++; if (word_start !== 1'b0) begin failures++; $display("FAIL reset_word_start got=%b exp=0", word_start); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    endtask

    task automatic test_preset0();
        int b;
        ena = 1'b1; use_preset = 1'b1; sel = 2'd0;
        do_reset();
        for (int k = 1; k <= WORDP + 25; k++) begin
            step();
            b = (cyc / BITP) % WB;
            checks++; if (msg !== p0[29-b]) begin failures++; $display("FAIL preset0_msg cyc=%0d got=%b exp=%b", cyc, msg, p0[29-b]); end
            checks++; if (epoch !== (cyc % CHIPS == 0)) begin failures++; $display("FAIL preset0_epoch cyc=%0d got=%b", cyc, epoch); end
            checks++; if (bit_start !== (cyc % BITP == 0)) begin failures++; $display("FAIL preset0_bit_start cyc=%0d got=%b", cyc, bit_start); end
            checks++; if (word_start !== (cyc % WORDP == 0)) begin failures++; $display("FAIL preset0_word_start cyc=%0d got=%b", cyc, word_start); end
        end
    endtask

    task automatic test_half_rate();
        int e;
        use_preset = 1'b1; sel = 2'd0; ena = 1'b0;
        do_reset();
        for (int k = 1; k <= 2 * BITP * 5; k++) begin
            ena = (k % 2 == 1);
            step();
            e = (k + 1) / 2;
            checks++; if (epoch !== (ena && e % CHIPS == 0)) begin failures++; $display("FAIL half_epoch k=%0d got=%b", k, epoch); end
            checks++; if (bit_start !== (ena && e % BITP == 0)) begin failures++; $display("FAIL half_bit_start k=%0d got=%b", k, bit_start); end
            checks++; if (msg !== p0[29-e/BITP]) begin failures++; $display("FAIL half_msg k=%0d got=%b exp=%b", k, msg, p0[29-e/BITP]); end
        end
        ena = 1'b1;
    endtask

    task automatic test_user_load();
        ena = 1'b1; use_preset = 1'b0; sel = 2'd0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            lv = 1'b1; lb = wa[29-i];
            step();
        end
        lv = 1'b0;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL load_full_set got=%b exp=1", full); end
        checks++; if (msg !== 1'b0) begin failures++; $display("FAIL load_msg_unchanged got=%b exp=0", msg); end
        for (int i = 0; i < 3; i++) begin
            lv = 1'b1; lb = 1'b0;
            step();
        end
        lv = 1'b0;
        while (cyc < WORDP - 1) step();
        checks++; if (word_start !== 1'b0 || full !== 1'b1) begin failures++; $display("FAIL load_pre_boundary ws=%b full=%b exp ws=0 full=1", word_start, full); end
        step();
        checks++; if (word_start !== 1'b1) begin failures++; $display("FAIL load_word_start got=%b exp=1", word_start); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL load_full_clear got=%b exp=0", full); end
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL load_bit0 got=%b exp=1", msg); end
        for (int b = 1; b <= 3; b++) begin
            while (cyc < WORDP + b * BITP + 5) step();
            checks++; if (msg !== wa[29-b]) begin failures++; $display("FAIL load_bit%0d got=%b exp=%b", b, msg, wa[29-b]); end
        end
        while (cyc < 2 * WORDP + 2 * BITP + 3) step();
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL load_repeat got=%b exp=1", msg); end
    endtask

    task automatic test_back_to_back();
        ena = 1'b1; use_preset = 1'b0; sel = 2'd0;
        do_reset();
        while (cyc < WORDP - 30) step();
        for (int i = 0; i < 30; i++) begin
            lv = 1'b1; lb = p3[29-i];
            step();
        end
        lv = 1'b0;
        checks++; if (word_start !== 1'b1) begin failures++; $display("FAIL b2b_word_start got=%b exp=1", word_start); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL b2b_full_held got=%b exp=1", full); end
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL b2b_old_bit0 got=%b exp=1", msg); end
        while (cyc < WORDP + BITP + 2) step();
        checks++; if (msg !== 1'b0) begin failures++; $display("FAIL b2b_old_bit1 got=%b exp=0", msg); end
        while (cyc < 2 * WORDP) step();
        checks++; if (word_start !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL b2b_second_boundary ws=%b full=%b exp ws=1 full=0", word_start, full); end
        checks++; if (msg !== 1'b0) begin failures++; $display("FAIL b2b_new_bit0 got=%b exp=0", msg); end
        while (cyc < 2 * WORDP + BITP + 2) step();
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL b2b_new_bit1 got=%b exp=1", msg); end
    endtask

    task automatic test_sync();
        ena = 1'b1; use_preset = 1'b1; sel = 2'd3;
        do_reset();
        while (cyc < 4 * BITP + 3) step();
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL sync_sel_ignored got=%b exp=1", msg); end
        while (cyc < 12 * BITP + 1 * CHIPS + 5) step();
        checks++; if (msg !== p0[17]) begin failures++; $display("FAIL sync_pre got=%b exp=%b", msg, p0[17]); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (bit_start !== 1'b1) begin failures++; $display("FAIL sync_bit_start got=%b exp=1", bit_start); end
        checks++; if (word_start !== 1'b1) begin failures++; $display("FAIL sync_word_start got=%b exp=1", word_start); end
        checks++; if (epoch !== 1'b0) begin failures++; $display("FAIL sync_epoch got=%b exp=0", epoch); end
        checks++; if (dut.u_timing.bit_idx_q !== 5'd0) begin failures++; $display("FAIL sync_bit_idx got=%0d exp=0", dut.u_timing.bit_idx_q); end
        checks++; if (msg !== p3[29]) begin failures++; $display("FAIL sync_msg got=%b exp=%b", msg, p3[29]); end
        repeat (CHIPS) step();
        checks++; if (epoch !== 1'b1) begin failures++; $display("FAIL sync_first_epoch got=%b exp=1", epoch); end
        repeat (BITP - CHIPS) step();
        checks++; if (bit_start !== 1'b1) begin failures++; $display("FAIL sync_next_bit got=%b exp=1", bit_start); end
        checks++; if (msg !== p3[28]) begin failures++; $display("FAIL sync_next_msg got=%b exp=%b", msg, p3[28]); end
    endtask

    task automatic test_reset_midload();
        ena = 1'b1; use_preset = 1'b0; sel = 2'd0;
        do_reset();
        while (cyc < BITP) step();
        for (int i = 0; i < 17; i++) begin
            lv = 1'b1; lb = 1'b1;
            step();
        end
        lv = 1'b0;
        checks++; if (msg !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL midload_pre msg=%b full=%b exp msg=0 full=0", msg, full); end
        rst = 1'b1;
        #1;
        checks++; if (msg !== 1'b1) begin failures++; $display("FAIL midload_rst_msg got=%b exp=1", msg); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL midload_rst_full got=%b exp=0", full); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 29; i++) begin
            lv = 1'b1; lb = wa[29-i];
            step();
        end
        lv = 1'b0;
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL midload_29 got=%b exp=0", full); end
        lv = 1'b1; lb = wa[0];
        step();
        lv = 1'b0;
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL midload_30 got=%b exp=1", full); end
        while (cyc < WORDP + 2 * BITP + 2) step();
        checks++; if (msg !== wa[27]) begin failures++; $display("FAIL midload_word got=%b exp=%b", msg, wa[27]); end
    endtask

    initial begin
        test_reset();
        test_preset0();
        test_half_rate();
        test_user_load();
        test_back_to_back();
        test_sync();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nav_msg_gen.md
NAV_MSG_GEN -- requirements
Module: nav_msg_gen

Interface
REQ-001 Parameter: CA_CODE_LEN, default 1023, chips per C/A code epoch.
REQ-002 Parameter: EPOCHS_PER_BIT, default 20, code epochs per navigation data bit (50 bps).
REQ-003 Parameter: WORD_BITS, default 30, bits per navigation word.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  asynchronous active-high reset.
REQ-007 ena_in  input  1  chip-rate enable; the same strobe that advances the Gold code generator.
REQ-008 sync_in  input  1  restart pulse; realigns bit timing with a code generator restart.
REQ-009 use_msg_preset_in  input  1  1 = transmit the preset word; 0 = transmit the user-loaded word.
REQ-010 preset_sel_in  input  2  selects one of four preset words.
REQ-011 load_valid_in  input  1  one-clock strobe qualifying load_bit_in.
REQ-012 load_bit_in  input  1  serial user-word bit, MSB first.
REQ-013 msg_out  output  1  navigation data bit; feeds msg_in of the signal generator core.
REQ-014 epoch_out  output  1  one-clock pulse per code epoch.
REQ-015 bit_start_out  output  1  one-clock pulse per data-bit boundary.
REQ-016 word_start_out  output  1  one-clock pulse per word boundary.
REQ-017 load_full_out  output  1  staging register holds a complete user word not yet transferred.

Function
REQ-018 chip_cnt (0..CA_CODE_LEN-1), epoch_cnt (0..EPOCHS_PER_BIT-1) and bit_idx (0..WORD_BITS-1) SHALL advance only on clocks with ena_in=1; chip_cnt wraps to 0 after 1022 and then increments epoch_cnt; epoch_cnt wraps after 19 and then increments bit_idx; bit_idx wraps after 29.
REQ-019 msg_out SHALL equal active_word[WORD_BITS-1-bit_idx], driven from registers only, with no combinational path from any input.
REQ-020 epoch_out, bit_start_out and word_start_out SHALL each be registered and asserted for exactly the one clock following the edge at which chip_cnt, epoch_cnt or bit_idx respectively wrapped.
REQ-021 At a word boundary (bit_idx wrapping from 29 to 0), active_word SHALL be reloaded on the same edge, using the values sampled on that edge:
- use_msg_preset_in=1: the preset selected by preset_sel_in.
- use_msg_preset_in=0 and load_full_out=1: the staging word, with load_full_out cleared.
- use_msg_preset_in=0 and load_full_out=0: the current active_word is retained (repeats).
REQ-022 use_msg_preset_in and preset_sel_in SHALL have no effect except at a word boundary or on sync_in.
REQ-023 Each load_valid_in pulse SHALL shift load_bit_in into the LSB of a 30-bit staging register.
- A load counter tracks received bits; on the 30th bit, load_full_out is set.
- While load_full_out=1, load_valid_in is ignored.
REQ-024 If a staging word completes on the same edge as a word boundary, the transfer decision SHALL use the pre-edge load_full_out value (0), so the new word transfers at the next boundary.
REQ-025 sync_in=1 SHALL override ena_in on the same edge:
- chip_cnt, epoch_cnt and bit_idx are cleared.
- active_word is reloaded per REQ-021.
- word_start_out and bit_start_out pulse on the next clock.
- epoch_out does not pulse.
REQ-026 The staging register and load counter SHALL be unaffected by sync_in.
REQ-027 Preset words SHALL be:
- PRESET0 = 30'h22C00000 (TLM preamble 10001011 followed by zeros).
- PRESET1 = 30'h3FFFFFFF.
- PRESET2 = 30'h00000000.
- PRESET3 = 30'h15555555.
REQ-028 The bit period SHALL be 20460 enabled clocks and the word period 613800 enabled clocks.

Reset
REQ-029 While rst_in=1, all counters SHALL be 0, active_word SHALL be PRESET0, staging SHALL be 0, and load_full_out SHALL be 0.
REQ-030 Outputs in reset SHALL be: msg_out=1, epoch_out=0, bit_start_out=0, word_start_out=0.
REQ-031 Reset asserted mid-word SHALL discard any partial staging word.

Structure
REQ-032 CA_CODE_LEN, EPOCHS_PER_BIT, WORD_BITS and PRESET0..3 SHALL reside in shared package gps_pkg.
REQ-033 The chip/epoch/bit counters and pulse generation SHALL be one sub-module, nav_timing_cntr; word select, staging and output logic SHALL be in nav_msg_gen.

Verification
REQ-034 Reset, then ena_in=1 continuously with preset 0 selected -> msg_out=1 for 20460 clocks, then the sequence 0,0,0,1,0,1,1, then 22 zeros, each bit lasting 20460 clocks.
REQ-035 ena_in toggled 1/0 every clock -> epoch_out period is 2046 clocks and msg_out bit period is 40920 clocks.
REQ-036 Serially load 30'h2AAAAAAA with use_msg_preset_in=0 -> load_full_out=1 after the 30th pulse; at the next word_start_out, msg_out shows 1,0,1,0,... and load_full_out=0.
REQ-037 Complete a staging load on the exact word-boundary edge -> the old word repeats once, and the new word starts at the following boundary.
REQ-038 Assert sync_in at chip_cnt=500, epoch_cnt=7, bit_idx=12 with ena_in=1 -> the next clock shows bit_start_out=1, word_start_out=1, epoch_out=0, bit_idx=0, and msg_out equal to the MSB of the selected preset.
REQ-039 Assert rst_in mid-load after 17 load pulses -> load_full_out=0 and msg_out=1 immediately; 30 fresh pulses are then required to set load_full_out.
